// File: rtl/uop_instr_queue.sv
// Circular uop FIFO between decode and rename/issue; multi-push, prefix-pop, one-cycle flush.
// Outputs depend on registered head/tail only; decode must stall while ready is low.

package uop_instr_queue_pkg;
  typedef struct packed {
    logic        tx_begin;
    logic        tx_end;
    logic [7:0]  op;
    logic [15:0] tag;
  } uop_insn;
endpackage

module uop_instr_queue
  import uop_instr_queue_pkg::*;
#(
  parameter int INSTR_Q_DEPTH = 16,
  parameter int INSTR_Q_WIDTH = 4,
  parameter int ISSUE_WIDTH   = 2,
  parameter int CW = $clog2(INSTR_Q_WIDTH + 1),
  parameter int DW = $clog2(ISSUE_WIDTH + 1),
  parameter int OW = $clog2(INSTR_Q_DEPTH + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                flush_in,
  input  logic [CW-1:0]                       push_count_in,
  input  uop_insn [INSTR_Q_WIDTH-1:0]         push_uops_in,
  output logic                                ready_out,
  output uop_insn [ISSUE_WIDTH-1:0]           deq_uops_out,
  output logic [ISSUE_WIDTH-1:0]              deq_valid_out,
  input  logic [DW-1:0]                       deq_count_in,
  output logic [OW-1:0]                       occupancy_out,
  output logic                                overflow_err_out,
  output logic                                underflow_err_out
);

  localparam int AW = $clog2(INSTR_Q_DEPTH);
  localparam int PW = AW + 1;

  uop_insn        storage [INSTR_Q_DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [OW-1:0]  occ;
  logic [OW-1:0]  free_slots;
  logic [CW-1:0]  push_k;
  logic [DW-1:0]  avail;
  logic [DW-1:0]  pop_p;
  logic           push_req;
  logic           push_en;
  logic           overflow_hit;
  logic           underflow_hit;
  logic [AW-1:0]  wr_idx [INSTR_Q_WIDTH];

  // Wrap bit in head/tail makes full (16) distinguishable from empty (0).
  assign occ        = OW'(tail - head);
  assign free_slots = OW'(INSTR_Q_DEPTH) - occ;
  assign ready_out  = free_slots >= OW'(INSTR_Q_WIDTH);

  assign occupancy_out = occ;

  always_comb begin
    deq_valid_out = '0;
    deq_uops_out  = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      deq_valid_out[i] = OW'(i) < occ;
      deq_uops_out[i]  = storage[head[AW-1:0] + AW'(i)];
    end
  end

  assign push_k   = (push_count_in > CW'(INSTR_Q_WIDTH)) ? CW'(INSTR_Q_WIDTH) : push_count_in;
  assign push_req = push_k != '0;
  assign push_en  = push_req && ready_out && !flush_in;

  assign avail = (occ >= OW'(ISSUE_WIDTH)) ? DW'(ISSUE_WIDTH) : DW'(occ);
  assign pop_p = (deq_count_in > avail) ? avail : deq_count_in;

  // A flushed cycle discards the push/pop attempt, so it cannot raise an error either.
  assign overflow_hit  = push_req && !ready_out && !flush_in;
  assign underflow_hit = (deq_count_in > avail) && !flush_in;

  always_comb begin
    for (int j = 0; j < INSTR_Q_WIDTH; j++) begin
      wr_idx[j] = tail[AW-1:0] + AW'(j);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head              <= '0;
      tail              <= '0;
      overflow_err_out  <= 1'b0;
      underflow_err_out <= 1'b0;
    end else if (flush_in) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + PW'(pop_p);
      if (push_en) begin
        tail <= tail + PW'(push_k);
      end
      if (overflow_hit) begin
        overflow_err_out <= 1'b1;
      end
      if (underflow_hit) begin
        underflow_err_out <= 1'b1;
      end
    end
  end

  // Payload RAM carries no reset; only the pointers define validity.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_en) begin
      for (int j = 0; j < INSTR_Q_WIDTH; j++) begin
        if (CW'(j) < push_k) begin
          storage[wr_idx[j]] <= push_uops_in[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_uop_instr_queue.sv
// Directed bench for uop_instr_queue: reset, push/pop, fill, wrap, mixed, flush/reset.
module tb_uop_instr_queue;
  import uop_instr_queue_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 flush_in;
  logic [2:0]           push_count_in;
  uop_insn [3:0]        push_uops_in;
  logic                 ready_out;
  uop_insn [1:0]        deq_uops_out;
  logic [1:0]           deq_valid_out;
  logic [1:0]           deq_count_in;
  logic [4:0]           occupancy_out;
  logic                 overflow_err_out;
  logic                 underflow_err_out;

  int checks = 0;
  int errors = 0;

  uop_instr_queue dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .flush_in         (flush_in),
    .push_count_in    (push_count_in),
    .push_uops_in     (push_uops_in),
    .ready_out        (ready_out),
    .deq_uops_out     (deq_uops_out),
    .deq_valid_out    (deq_valid_out),
    .deq_count_in     (deq_count_in),
    .occupancy_out    (occupancy_out),
    .overflow_err_out (overflow_err_out),
    .underflow_err_out(underflow_err_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic uop_insn mk(input int t);
    uop_insn u;
    u.tag      = 16'(t);
    u.op       = 8'(t) ^ 8'h5a;
    u.tx_begin = t[0];
    u.tx_end   = ~t[0];
    return u;
  endfunction

  // Inputs change 1 time unit after the edge and outputs are sampled there too.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_push(input int k, input int base);
    push_count_in = 3'(k);
    for (int j = 0; j < 4; j++) push_uops_in[j] = mk(base + j);
  endtask

  task automatic idle_inputs();
    flush_in      = 1'b0;
    push_count_in = 3'd0;
    deq_count_in  = 2'd0;
    for (int j = 0; j < 4; j++) push_uops_in[j] = mk(16'hdead);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_out); end
    checks++; if (deq_valid_out !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", deq_valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_out); end
    checks++; if ({overflow_err_out, underflow_err_out} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b%b exp 00", overflow_err_out, underflow_err_out); end
  endtask

  task automatic test_push_pop();
    do_reset();
    set_push(3, 16'h00a);
    step();
    push_count_in = 3'd0;
    checks++; if (deq_valid_out !== 2'b11) begin errors++; $display("FAIL pp_valid got %b exp 11", deq_valid_out); end
    checks++; if (deq_uops_out[0] !== mk(16'h00a) || deq_uops_out[1] !== mk(16'h00b)) begin
      errors++; $display("FAIL pp_out got %h/%h exp a/b", deq_uops_out[0].tag, deq_uops_out[1].tag); end
    checks++; if (occupancy_out !== 5'd3) begin errors++; $display("FAIL pp_occ3 got %0d exp 3", occupancy_out); end
    deq_count_in = 2'd2;
    step();
    deq_count_in = 2'd0;
    checks++; if (deq_valid_out !== 2'b01) begin errors++; $display("FAIL pp_valid1 got %b exp 01", deq_valid_out); end
    checks++; if (deq_uops_out[0] !== mk(16'h00c)) begin
      errors++; $display("FAIL pp_outc got %h exp c", deq_uops_out[0].tag); end
    checks++; if (occupancy_out !== 5'd1) begin errors++; $display("FAIL pp_occ1 got %0d exp 1", occupancy_out); end
    checks++; if (underflow_err_out !== 1'b0) begin errors++; $display("FAIL pp_uflow got %b exp 0", underflow_err_out); end
  endtask

  task automatic test_fill_overflow();
    int exp_occ;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_push(4, c * 4);
      step();
      exp_occ = (c + 1) * 4;
      checks++; if (occupancy_out !== 5'(exp_occ)) begin
        errors++; $display("FAIL fill_occ got %0d exp %0d", occupancy_out, exp_occ); end
      checks++; if (ready_out !== (exp_occ <= 12)) begin
        errors++; $display("FAIL fill_ready at %0d got %b exp %b", exp_occ, ready_out, exp_occ <= 12); end
    end
    set_push(2, 100);
    step();
    push_count_in = 3'd0;
    checks++; if (occupancy_out !== 5'd16) begin errors++; $display("FAIL ovf_occ got %0d exp 16", occupancy_out); end
    checks++; if (overflow_err_out !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_err_out); end
    checks++; if (deq_uops_out[0].tag !== 16'd0 || deq_uops_out[1].tag !== 16'd1) begin
      errors++; $display("FAIL full_head got %0d/%0d exp 0/1", deq_uops_out[0].tag, deq_uops_out[1].tag); end
    step();
    checks++; if (overflow_err_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err_out); end
  endtask

  task automatic test_wrap();
    int exp_tag;
    do_reset();
    set_push(2, 0);
    step();
    exp_tag = 0;
    for (int c = 1; c < 20; c++) begin
      set_push(2, c * 2);
      deq_count_in = 2'd2;
      checks++; if (deq_uops_out[0].tag !== 16'(exp_tag) || deq_uops_out[1].tag !== 16'(exp_tag + 1)) begin
        errors++; $display("FAIL wrap_order got %0d/%0d exp %0d/%0d",
                           deq_uops_out[0].tag, deq_uops_out[1].tag, exp_tag, exp_tag + 1); end
      step();
      exp_tag += 2;
      checks++; if (occupancy_out !== 5'd2) begin errors++; $display("FAIL wrap_occ got %0d exp 2", occupancy_out); end
    end
    push_count_in = 3'd0;
    checks++; if (deq_uops_out[0].tag !== 16'd38 || deq_uops_out[1].tag !== 16'd39) begin
      errors++; $display("FAIL wrap_last got %0d/%0d exp 38/39", deq_uops_out[0].tag, deq_uops_out[1].tag); end
    step();
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", occupancy_out); end
    deq_count_in = 2'd0;
  endtask

  task automatic test_mixed();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_push(4, c * 4);
      step();
    end
    set_push(4, 12);
    deq_count_in = 2'd2;
    checks++; if (deq_uops_out[0].tag !== 16'd0 || deq_uops_out[1].tag !== 16'd1) begin
      errors++; $display("FAIL mix_oldest got %0d/%0d exp 0/1", deq_uops_out[0].tag, deq_uops_out[1].tag); end
    step();
    idle_inputs();
    checks++; if (occupancy_out !== 5'd14) begin errors++; $display("FAIL mix_occ got %0d exp 14", occupancy_out); end
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL mix_ready got %b exp 0", ready_out); end
    checks++; if (deq_uops_out[0].tag !== 16'd2 || deq_uops_out[1].tag !== 16'd3) begin
      errors++; $display("FAIL mix_head got %0d/%0d exp 2/3", deq_uops_out[0].tag, deq_uops_out[1].tag); end
    // Oversized push count is clamped to four.
    do_reset();
    set_push(7, 200);
    step();
    push_count_in = 3'd0;
    checks++; if (occupancy_out !== 5'd4) begin errors++; $display("FAIL clamp_occ got %0d exp 4", occupancy_out); end
    checks++; if (overflow_err_out !== 1'b0) begin errors++; $display("FAIL clamp_ovf got %b exp 0", overflow_err_out); end
    do_reset();
    set_push(1, 300);
    step();
    push_count_in = 3'd0;
    deq_count_in  = 2'd2;
    checks++; if (deq_valid_out !== 2'b01) begin errors++; $display("FAIL uf_valid got %b exp 01", deq_valid_out); end
    step();
    deq_count_in = 2'd0;
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("FAIL uf_occ got %0d exp 0", occupancy_out); end
    checks++; if (underflow_err_out !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", underflow_err_out); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    deq_count_in = 2'd1;
    step();
    deq_count_in = 2'd0;
    set_push(4, 0);
    step();
    step();
    checks++; if (occupancy_out !== 5'd8) begin errors++; $display("FAIL fl_pre got %0d exp 8", occupancy_out); end
    flush_in     = 1'b1;
    set_push(4, 8);
    deq_count_in = 2'd2;
    step();
    idle_inputs();
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", occupancy_out); end
    checks++; if (deq_valid_out !== 2'b00) begin errors++; $display("FAIL fl_valid got %b exp 00", deq_valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL fl_ready got %b exp 1", ready_out); end
    checks++; if ({overflow_err_out, underflow_err_out} !== 2'b01) begin
      errors++; $display("FAIL fl_err got %b%b exp 01", overflow_err_out, underflow_err_out); end
    set_push(4, 20);
    step();
    rst_in = 1'b1;
    set_push(4, 24);
    deq_count_in = 2'd2;
    step();
    rst_in = 1'b0;
    idle_inputs();
    checks++; if (occupancy_out !== 5'd0) begin errors++; $display("FAIL rs_occ got %0d exp 0", occupancy_out); end
    checks++; if (deq_valid_out !== 2'b00) begin errors++; $display("FAIL rs_valid got %b exp 00", deq_valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rs_ready got %b exp 1", ready_out); end
    checks++; if ({overflow_err_out, underflow_err_out} !== 2'b00) begin
      errors++; $display("FAIL rs_err got %b%b exp 00", overflow_err_out, underflow_err_out); end
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    test_reset();
    test_push_pop();
    test_fill_overflow();
    test_wrap();
    test_mixed();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
